fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-002 Parameter IMEM_TIMEOUT, default 15, SHALL be the max REQ cycles without imem_ack before a timeout error; range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc_in  input  32  SHALL be the current PC value from the PC register output.
REQ-006 pc_ena  output  1  SHALL be the PC register load enable, asserted for exactly one cycle per PC update.
REQ-007 pc_next  output  32  SHALL be the PC register data input; 0 when pc_ena=0.
REQ-008 imem_req  output  1  SHALL request an instruction-memory read.
REQ-009 imem_addr  output  32  SHALL be the read address; equals pc_in while imem_req=1, else 0.
REQ-010 imem_ack  input  1  SHALL mark imem_data valid; ignored unless imem_req=1.
REQ-011 imem_data  input  32  SHALL be the fetched instruction word.
REQ-012 instr_valid / instr  output  1 / 32  SHALL present the held instruction downstream.
REQ-013 instr_ready  input  1  SHALL be the downstream accept; transfer when instr_valid & instr_ready.
REQ-014 redirect_valid / redirect_pc  input  1 / 32  SHALL request a PC redirect (branch/jump) to redirect_pc.
REQ-015 fetch_err / err_code  output  1 / 2  SHALL flag a fatal fetch error; err_code 01=timeout, 10=misaligned, 00=none.

Function
REQ-016 FSM SHALL have states IDLE, REQ, HOLD, ERR.
REQ-017 IDLE SHALL go to REQ on the first clock edge after rst deasserts.
REQ-018 In REQ with pc_in[1:0]!=0, imem_req SHALL be 0 and the FSM SHALL go to ERR with err_code=10.
REQ-019 In REQ with aligned pc_in, imem_req SHALL be 1; the wait counter SHALL increment each cycle without imem_ack and clear on entry to REQ.
REQ-020 Counter reaching IMEM_TIMEOUT without imem_ack SHALL move the FSM to ERR with err_code=01.
REQ-021 redirect_valid in REQ without imem_ack SHALL store redirect_pc as pending; a later redirect overwrites it (latest wins).
REQ-022 imem_ack in REQ with a pending redirect or redirect_valid=1 in that cycle SHALL discard imem_data, assert pc_ena with pc_next=redirect target (the current-cycle redirect_pc has priority over pending), clear pending, and remain in REQ (counter cleared).
REQ-023 imem_ack in REQ with no redirect SHALL latch imem_data into instr and go to HOLD.
REQ-024 In HOLD, instr_valid SHALL be 1 and instr SHALL be stable until transfer or redirect.
REQ-025 HOLD transfer without redirect SHALL assert pc_ena with pc_next=(pc_in+PC_STEP) mod 2^32 and go to REQ.
REQ-026 redirect_valid in HOLD (with or without instr_ready) SHALL assert pc_ena with pc_next=redirect_pc, drop instr_valid next cycle, and go to REQ; a concurrent transfer counts as consumed.
REQ-027 pc_ena/pc_next SHALL be combinational from state and inputs in the deciding cycle; PC register loads on that edge; the following REQ cycle uses the updated pc_in.
REQ-028 ERR SHALL hold fetch_err=1 and err_code, with pc_ena, imem_req and instr_valid at 0; exit only via reset.
REQ-029 redirect_valid in IDLE or ERR SHALL be ignored.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, pc_ena=0, pc_next=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, fetch_err=0, err_code=00, pending cleared, counter 0, regardless of clock.
REQ-031 Reset mid-REQ or mid-HOLD SHALL abandon the outstanding fetch; a late imem_ack after reset SHALL be ignored until a new REQ.

Verification
REQ-032 Sequential: pc_in=0x0, ack in first REQ cycle with data 0xDEADBEEF, ready=1 -> instr=0xDEADBEEF valid one cycle, pc_ena pulse with pc_next=0x4, next imem_addr=0x4.
REQ-033 Wrap: pc_in=0xFFFFFFFC, fetch and transfer -> pc_next=0x00000000.
REQ-034 Redirect in REQ: redirect_valid with redirect_pc=0x100 two cycles before ack -> data discarded, instr_valid stays 0, pc_next=0x100, next imem_addr=0x100.
REQ-035 Redirect+ready same HOLD cycle, redirect_pc=0x40 -> pc_next=0x40, not pc_in+4.
REQ-036 Timeout: imem_ack held 0 for 15 REQ cycles -> fetch_err=1, err_code=01, imem_req=0; persists until rst=0.
REQ-037 Misaligned + async reset: pc_in=0x2 -> err_code=10, no imem_req; rst pulsed low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests a word for the current PC, holds it for the
// decoder, steps or redirects the external PC register, and latches fatal fetch errors.
module fetch_ctrl #(
    parameter int PC_STEP      = 4,
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // Wait counter value seen on the last permitted ack-less REQ cycle.
    localparam logic [7:0]  WAIT_LAST = 8'(IMEM_TIMEOUT - 1);
    localparam logic [31:0] STEP      = 32'(PC_STEP);

    logic [1:0]  state,      state_nxt;
    logic [7:0]  wait_cnt,   wait_cnt_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_pc,    pend_pc_nxt;
    logic [31:0] instr_q,    instr_nxt;
    logic [1:0]  err_q,      err_nxt;

    logic        misaligned;
    logic        redirect_hit;
    logic [31:0] redirect_tgt;

    assign misaligned   = (pc_in[1:0] != 2'b00);
    assign redirect_hit = redirect_valid | pend_valid;
    // A redirect arriving in the ack cycle is newer than anything pending.
    assign redirect_tgt = redirect_valid ? redirect_pc : pend_pc;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = 8'd0;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        instr_nxt      = instr_q;
        err_nxt        = err_q;
        pc_ena         = 1'b0;
        pc_next        = 32'd0;
        imem_req       = 1'b0;
        imem_addr      = 32'd0;
        instr_valid    = 1'b0;
        fetch_err      = 1'b0;
        err_code       = ERR_NONE;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end

            S_REQ: begin
                if (misaligned) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_MISALIGN;
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = pc_in;
                    if (imem_ack) begin
                        if (redirect_hit) begin
                            // Returned word belongs to the abandoned path: drop it and refetch.
                            pc_ena         = 1'b1;
                            pc_next        = redirect_tgt;
                            pend_valid_nxt = 1'b0;
                        end else begin
                            instr_nxt = imem_data;
                            state_nxt = S_HOLD;
                        end
                    end else begin
                        if (redirect_valid) begin
                            pend_valid_nxt = 1'b1;
                            pend_pc_nxt    = redirect_pc;
                        end
                        if (wait_cnt == WAIT_LAST) begin
                            state_nxt = S_ERR;
                            err_nxt   = ERR_TIMEOUT;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 8'd1;
                        end
                    end
                end
            end

            S_HOLD: begin
                instr_valid = 1'b1;
                if (redirect_valid) begin
                    pc_ena    = 1'b1;
                    pc_next   = redirect_pc;
                    state_nxt = S_REQ;
                end else if (instr_ready) begin
                    pc_ena    = 1'b1;
                    pc_next   = pc_in + STEP;
                    state_nxt = S_REQ;
                end
            end

            S_ERR: begin
                fetch_err = 1'b1;
                err_code  = err_q;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr = instr_q;

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values; the held instruction is an ordinary register and is reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
            instr_q    <= 32'd0;
            err_q      <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            instr_q    <= instr_nxt;
            err_q      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the PC register and fetch semantics, compares every
// cycle, and pins key scenarios with literal expectations.
module tb_fetch_ctrl;

    localparam int PC_STEP      = 4;
    localparam int IMEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fetch_err;
    logic [1:0]  err_code;

    logic        pc_set = 1'b0;
    logic [31:0] pc_set_val = 32'd0;
    logic [31:0] pc_reg = 32'd0;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.PC_STEP(PC_STEP), .IMEM_TIMEOUT(IMEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_reg),
        .pc_ena(pc_ena), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // External PC register; the bench can preload it while the DUT is in reset.
    always @(posedge clk) begin
        if (pc_set)      pc_reg <= pc_set_val;
        else if (pc_ena) pc_reg <= pc_next;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch-level model: is a fetch outstanding, is a word being offered, what fault.
    bit          m_started, m_fetching, m_holding;
    logic [31:0] m_word;
    logic [1:0]  m_fault;
    int          m_wait;
    logic [31:0] m_pend[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_started = 0; m_fetching = 0; m_holding = 0;
            m_word = 32'd0; m_fault = 2'b00; m_wait = 0;
            m_pend.delete();
        end else if (!m_started) begin
            m_started = 1; m_fetching = 1; m_wait = 0;
        end else if (m_fetching) begin
            if (pc_reg[1:0] != 2'b00) begin
                m_fetching = 0; m_fault = 2'b10;
            end else if (imem_ack) begin
                if (redirect_valid || m_pend.size() > 0) begin
                    m_pend.delete(); m_wait = 0;
                end else begin
                    m_word = imem_data; m_fetching = 0; m_holding = 1;
                end
            end else begin
                if (redirect_valid) begin
                    m_pend.delete(); m_pend.push_back(redirect_pc);
                end
                m_wait++;
                if (m_wait >= IMEM_TIMEOUT) begin
                    m_fetching = 0; m_fault = 2'b01;
                end
            end
        end else if (m_holding) begin
            if (redirect_valid || instr_ready) begin
                m_holding = 0; m_fetching = 1; m_wait = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        e_ena, e_req;
        logic [31:0] e_next, e_addr;
        e_ena = 1'b0; e_req = 1'b0; e_next = 32'd0; e_addr = 32'd0;
        if (m_fetching && pc_reg[1:0] == 2'b00) begin
            e_req  = 1'b1;
            e_addr = pc_reg;
            if (imem_ack && (redirect_valid || m_pend.size() > 0)) begin
                e_ena  = 1'b1;
                e_next = redirect_valid ? redirect_pc : m_pend[0];
            end
        end
        if (m_holding) begin
            if (redirect_valid) begin
                e_ena = 1'b1; e_next = redirect_pc;
            end else if (instr_ready) begin
                e_ena = 1'b1; e_next = pc_reg + 32'(PC_STEP);
            end
        end
        check("cyc_pc_ena",      32'(pc_ena),      32'(e_ena));
        check("cyc_pc_next",     pc_next,          e_next);
        check("cyc_imem_req",    32'(imem_req),    32'(e_req));
        check("cyc_imem_addr",   imem_addr,        e_addr);
        check("cyc_instr_valid", 32'(instr_valid), 32'(m_holding));
        check("cyc_fetch_err",   32'(fetch_err),   32'(m_fault != 2'b00));
        check("cyc_err_code",    32'(err_code),    32'(m_fault));
        if (m_holding || !rst)
            check("cyc_instr", instr, m_holding ? m_word : 32'd0);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state before any clock edge.
        pc_set = 1'b1; pc_set_val = 32'h0;
        #2;
        check("rst_pc_ena",   32'(pc_ena),   32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_valid",    32'(instr_valid), 32'd0);
        check("rst_err",      32'(fetch_err), 32'd0);
        check("rst_instr",    instr, 32'd0);
        tick(); tick();
        pc_set = 1'b0;
        rst = 1'b1;

        // Sequential fetch from 0.
        tick();
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF; instr_ready = 1'b1;
        #2;
        check("seq_req",  32'(imem_req), 32'd1);
        check("seq_addr", imem_addr, 32'h0);
        tick();
        imem_ack = 1'b0;
        #2;
        check("seq_valid",   32'(instr_valid), 32'd1);
        check("seq_instr",   instr, 32'hDEADBEEF);
        check("seq_pc_ena",  32'(pc_ena), 32'd1);
        check("seq_pc_next", pc_next, 32'h4);
        tick();
        instr_ready = 1'b0;
        #2;
        check("seq_valid_drop", 32'(instr_valid), 32'd0);
        check("seq_next_addr",  imem_addr, 32'h4);

        // Redirect in the ack cycle moves the PC to the top of memory; then wrap.
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        #1;
        check("ackredir_pc_next", pc_next, 32'hFFFFFFFC);
        tick();
        redirect_valid = 1'b0; imem_data = 32'h12345678;
        #2;
        check("wrap_addr", imem_addr, 32'hFFFFFFFC);
        tick();
        imem_ack = 1'b0;
        #2;
        check("wrap_stall_pc_ena", 32'(pc_ena), 32'd0);
        tick();
        instr_ready = 1'b1;
        #2;
        check("wrap_instr_stable", instr, 32'h12345678);
        check("wrap_pc_ena",       32'(pc_ena), 32'd1);
        check("wrap_pc_next",      pc_next, 32'h00000000);
        tick();
        instr_ready = 1'b0;

        // Redirects while waiting: latest wins, applied on the ack, data discarded.
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        #2;
        check("pend_no_pc_ena", 32'(pc_ena), 32'd0);
        tick();
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 32'hBAD0BAD0;
        #2;
        check("redir_req_pc_ena",  32'(pc_ena), 32'd1);
        check("redir_req_pc_next", pc_next, 32'h100);
        tick();
        imem_ack = 1'b0;
        #2;
        check("redir_req_valid", 32'(instr_valid), 32'd0);
        check("redir_req_addr",  imem_addr, 32'h100);

        // Current-cycle redirect beats the pending one.
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_ack = 1'b1; redirect_pc = 32'h340;
        #2;
        check("prio_pc_next", pc_next, 32'h340);
        tick();
        redirect_valid = 1'b0; imem_data = 32'hCAFEF00D;

        // Redirect and ready together in HOLD.
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        #2;
        check("hold_redir_instr",   instr, 32'hCAFEF00D);
        check("hold_redir_pc_next", pc_next, 32'h40);
        tick();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        #2;
        check("hold_redir_addr", imem_addr, 32'h40);

        // Timeout: 15 ack-less REQ cycles, then a sticky error.
        for (int i = 0; i < IMEM_TIMEOUT; i++) begin
            check("timeout_wait_req", 32'(imem_req), 32'd1);
            tick();
        end
        check("timeout_err",  32'(fetch_err), 32'd1);
        check("timeout_code", 32'(err_code), 32'd1);
        check("timeout_req",  32'(imem_req), 32'd0);
        imem_ack = 1'b1; redirect_valid = 1'b1; instr_ready = 1'b1;
        tick(); tick(); tick();
        check("err_sticky",      32'(err_code), 32'd1);
        check("err_no_pc_ena",   32'(pc_ena), 32'd0);
        imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;

        // Asynchronous reset between edges clears everything at once.
        rst = 1'b0;
        #1;
        check("areset_err",  32'(fetch_err), 32'd0);
        check("areset_code", 32'(err_code), 32'd0);
        pc_set = 1'b1; pc_set_val = 32'h2;
        tick();
        pc_set = 1'b0;
        rst = 1'b1;

        // Misaligned PC.
        tick();
        check("mis_req",  32'(imem_req), 32'd0);
        check("mis_addr", imem_addr, 32'd0);
        tick();
        check("mis_err",  32'(fetch_err), 32'd1);
        check("mis_code", 32'(err_code), 32'd2);
        rst = 1'b0;
        #1;
        check("mis_areset_code", 32'(err_code), 32'd0);

        // Reset mid-HOLD abandons the word; a late ack across reset is ignored.
        pc_set = 1'b1; pc_set_val = 32'h10;
        tick();
        pc_set = 1'b0;
        rst = 1'b1;
        tick();
        imem_ack = 1'b1; imem_data = 32'h55AA55AA;
        tick();
        check("midhold_valid", 32'(instr_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("midhold_rst_valid", 32'(instr_valid), 32'd0);
        check("midhold_rst_instr", instr, 32'd0);
        tick();
        rst = 1'b1;
        #2;
        check("late_ack_idle_valid", 32'(instr_valid), 32'd0);
        tick();
        imem_ack = 1'b0;
        #2;
        check("late_ack_req_addr", imem_addr, 32'h10);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
